// File: rtl/cache_pkg.sv
// Shared types and default geometry for the data cache.
package cache_pkg;

  // Controller states: serve hits in IDLE, wait out a memory read, or retire a store.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    WRITE     = 2'd2
  } state_t;

  localparam int DEFAULT_ADDRESS_LENGTH = 3;
  localparam int DEFAULT_INDEX_LENGTH   = 2;
  localparam int LINES                  = 1 << DEFAULT_INDEX_LENGTH;
  localparam int TAG_LENGTH             = DEFAULT_ADDRESS_LENGTH - DEFAULT_INDEX_LENGTH;

endpackage

// File: rtl/cache_storage.sv
// Line storage: valid/tag/data arrays with combinational read and one write port.
// Writing a line always marks it valid; only the valid bits are reset.
module cache_storage
  import cache_pkg::*;
#(
  parameter int INDEX_LENGTH = DEFAULT_INDEX_LENGTH,
  parameter int TAG_BITS     = TAG_LENGTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [INDEX_LENGTH-1:0] index,
  output logic                    line_valid,
  output logic [TAG_BITS-1:0]     line_tag,
  output logic [31:0]             line_data,
  input  logic                    wr_en,
  input  logic [TAG_BITS-1:0]     wr_tag,
  input  logic [31:0]             wr_data
);

  localparam int NUM_LINES = 1 << INDEX_LENGTH;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES];

  // Combinational lookup of the addressed line.
  always_comb begin
    line_valid = valid_q[index];
    line_tag   = tag_q[index];
    line_data  = data_q[index];
  end

  // Valid bits: cleared by reset, set by any line write.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[index] <= 1'b1;
    end
  end

  // Tag and data payload; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      tag_q[index]  <= wr_tag;
      data_q[index] <= wr_data;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Handshake: while cpu_stall is high the CPU holds cpu_read/cpu_write, cpu_address
// and cpu_write_data stable; a request is accepted in the first cycle it is seen
// in IDLE with cpu_stall low, and a new request may follow the cycle after stall falls.
module data_cache
  import cache_pkg::*;
#(
  parameter int ADDRESS_LENGTH = DEFAULT_ADDRESS_LENGTH,
  parameter int INDEX_LENGTH   = DEFAULT_INDEX_LENGTH,
  parameter int MEM_LATENCY    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDRESS_LENGTH-1:0] cpu_address,
  input  logic [31:0]               cpu_write_data,
  input  logic                      cpu_read,
  input  logic                      cpu_write,
  output logic [31:0]               cpu_read_data,
  output logic                      cpu_stall,
  output logic [ADDRESS_LENGTH-1:0] mem_address,
  output logic [31:0]               mem_write_data,
  output logic                      mem_write_enable,
  input  logic [31:0]               mem_read_data
);

  localparam int TAG_BITS = ADDRESS_LENGTH - INDEX_LENGTH;
  localparam int CNT_W    = $clog2(MEM_LATENCY) + 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_LATENCY - 1);

  state_t            state, next_state;
  logic [CNT_W-1:0]  count;

  logic [INDEX_LENGTH-1:0] index;
  logic [TAG_BITS-1:0]     tag;
  logic                    line_valid;
  logic [TAG_BITS-1:0]     line_tag;
  logic [31:0]             line_data;
  logic                    hit;
  logic                    line_wr_en;
  logic [31:0]             line_wr_data;

  assign index = cpu_address[INDEX_LENGTH-1:0];
  assign tag   = cpu_address[ADDRESS_LENGTH-1:INDEX_LENGTH];
  assign hit   = line_valid && (line_tag == tag);

  cache_storage #(
    .INDEX_LENGTH (INDEX_LENGTH),
    .TAG_BITS     (TAG_BITS)
  ) u_storage (
    .clk        (clk),
    .reset      (reset),
    .index      (index),
    .line_valid (line_valid),
    .line_tag   (line_tag),
    .line_data  (line_data),
    .wr_en      (line_wr_en),
    .wr_tag     (tag),
    .wr_data    (line_wr_data)
  );

  // Next state, CPU-facing outputs and line writes (fill or write-hit update).
  always_comb begin
    next_state    = state;
    cpu_stall     = 1'b0;
    cpu_read_data = '0;
    line_wr_en    = 1'b0;
    line_wr_data  = '0;
    unique case (state)
      IDLE: begin
        if (cpu_write) begin
          cpu_stall  = 1'b1;
          next_state = WRITE;
        end else if (cpu_read) begin
          if (hit) begin
            cpu_read_data = line_data;
          end else begin
            cpu_stall  = 1'b1;
            next_state = READ_WAIT;
          end
        end
      end
      READ_WAIT: begin
        cpu_stall = 1'b1;
        if (count == LAST_WAIT) begin
          line_wr_en   = 1'b1;
          line_wr_data = mem_read_data;
          next_state   = IDLE;
        end
      end
      WRITE: begin
        // Write-through without allocation: only an existing matching line is refreshed.
        if (hit) begin
          line_wr_en   = 1'b1;
          line_wr_data = cpu_write_data;
        end
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register, wait counter and registered memory port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      count            <= '0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      mem_write_enable <= 1'b0;
    end else begin
      state <= next_state;
      unique case (state)
        IDLE: begin
          mem_write_enable <= 1'b0;
          if (cpu_write) begin
            mem_address      <= cpu_address;
            mem_write_data   <= cpu_write_data;
            mem_write_enable <= 1'b1;
          end else if (cpu_read && !hit) begin
            mem_address <= cpu_address;
            count       <= '0;
          end
        end
        READ_WAIT: count <= count + CNT_W'(1);
        WRITE:     mem_write_enable <= 1'b0;
        default:   mem_write_enable <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a small behavioural main memory.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  cpu_address;
  logic [31:0] cpu_write_data;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_read_data;
  logic        cpu_stall;
  logic [2:0]  mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  int pass_count = 0;
  int check_count = 0;

  // clock/reset block
  always #5 clk = ~clk;

  data_cache #(
    .ADDRESS_LENGTH (3),
    .INDEX_LENGTH   (2),
    .MEM_LATENCY    (2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cpu_address      (cpu_address),
    .cpu_write_data   (cpu_write_data),
    .cpu_read         (cpu_read),
    .cpu_write        (cpu_write),
    .cpu_read_data    (cpu_read_data),
    .cpu_stall        (cpu_stall),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  // Main memory model: preloaded on the first edge, commits writes on posedge.
  logic [31:0] mem [8];
  logic        mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 8; i++) mem[i] <= 32'h0;
      mem[5]     <= 32'hDEADBEEF;
      mem[1]     <= 32'h00000011;
      mem_loaded <= 1'b1;
    end else if (mem_write_enable) begin
      mem[mem_address] <= mem_write_data;
    end
  end

  assign mem_read_data = mem[mem_address];

  // scoreboard helper
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic read_miss(input logic [2:0] addr, input logic [31:0] exp);
    next_cycle();
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_address = addr;
    #1;
    chk("miss_stall_idle", cpu_stall, 1);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      #1;
      chk("miss_stall_wait", cpu_stall, 1);
      chk("miss_mem_address", mem_address, addr);
    end
    next_cycle();
    #1;
    chk("miss_done_stall", cpu_stall, 0);
    chk("miss_done_data", cpu_read_data, exp);
    chk("miss_done_mwe", mem_write_enable, 0);
  endtask

  task automatic read_hit(input logic [2:0] addr, input logic [31:0] exp);
    next_cycle();
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_address = addr;
    #1;
    chk("hit_stall", cpu_stall, 0);
    chk("hit_data", cpu_read_data, exp);
    chk("hit_mwe", mem_write_enable, 0);
  endtask

  task automatic write_op(input logic [2:0] addr, input logic [31:0] data, input logic also_read);
    next_cycle();
    cpu_write = 1'b1; cpu_read = also_read; cpu_address = addr; cpu_write_data = data;
    #1;
    chk("wr_stall_idle", cpu_stall, 1);
    chk("wr_read_data_zero", cpu_read_data, 0);
    chk("wr_mwe_idle", mem_write_enable, 0);
    next_cycle();
    #1;
    chk("wr_stall_write", cpu_stall, 0);
    chk("wr_mwe_high", mem_write_enable, 1);
    chk("wr_mem_address", mem_address, addr);
    chk("wr_mem_data", mem_write_data, data);
    next_cycle();
    cpu_write = 1'b0; cpu_read = 1'b0;
    #1;
    chk("wr_mwe_low_after", mem_write_enable, 0);
    chk("wr_stall_after", cpu_stall, 0);
    chk("wr_mem_address_held", mem_address, addr);
    chk("wr_mem_data_held", mem_write_data, data);
    chk("wr_memory_commit", mem[addr], data);
  endtask

  // directed sequence
  initial begin
    reset = 1'b1;
    cpu_address = '0; cpu_write_data = '0; cpu_read = 1'b0; cpu_write = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    #1;
    chk("reset_stall", cpu_stall, 0);
    chk("reset_read_data", cpu_read_data, 0);
    chk("reset_mem_address", mem_address, 0);
    chk("reset_mem_write_data", mem_write_data, 0);
    chk("reset_mwe", mem_write_enable, 0);

    // cold miss then hit
    read_miss(3'd5, 32'hDEADBEEF);
    read_hit(3'd5, 32'hDEADBEEF);

    // conflict on index 1
    read_miss(3'd1, 32'h00000011);
    read_miss(3'd5, 32'hDEADBEEF);

    // write hit updates line and memory
    write_op(3'd5, 32'h12345678, 1'b0);
    read_hit(3'd5, 32'h12345678);

    // write miss: memory updated, no allocation
    write_op(3'd2, 32'hCAFEF00D, 1'b0);
    read_miss(3'd2, 32'hCAFEF00D);

    // write has priority over a simultaneous read (line 2 is a hit)
    write_op(3'd2, 32'h0BADF00D, 1'b1);
    read_hit(3'd2, 32'h0BADF00D);

    // reset during the second READ_WAIT cycle of a miss on 5
    read_miss(3'd1, 32'h00000011);
    next_cycle();
    cpu_read = 1'b1; cpu_address = 3'd5;
    #1;
    chk("rst_mid_stall_idle", cpu_stall, 1);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0; cpu_read = 1'b0;
    #1;
    chk("rst_mid_stall", cpu_stall, 0);
    chk("rst_mid_read_data", cpu_read_data, 0);
    chk("rst_mid_mwe", mem_write_enable, 0);
    chk("rst_mid_mem_address", mem_address, 0);
    read_miss(3'd5, 32'h12345678);

    next_cycle();
    cpu_read = 1'b0;
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
